drum_mult_arbiter: RTL

Round-robin arbiter and two-stage pipeline that shares one 16x16 DRUM approximate multiplier among `NREQ` requesters. Each requester presents operand pairs over a valid/ready handshake. A per-requester configuration mask selects DRUM-approximate or exact multiplication. Tagged 32-bit results return on a single valid/ready response port, so several accelerator lanes can use one multiplier instance without duplicating it.

---
 rtl/drum_mult_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/drum_mult_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared 16x16
// DRUM approximate multiplier, with per-requester exact-mode override.
module drum_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      exact_mask,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_r,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_exact,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  typedef struct packed {
    logic [5:0] mm;
    logic [3:0] p;
  } drum_seg_t;

  // Six-bit mantissa {1, next four bits, 1} plus shift, from the leading one.
  function automatic drum_seg_t drum_seg(input logic [15:0] x);
    drum_seg_t   seg;
    logic [15:0] top;
    int          k;
    k = 0;
    for (int j = 0; j < 16; j++) begin
      if (x[j]) k = j;
    end
    top = x >> (k - 4);
    if (k <= 5) begin
      seg.mm = x[5:0];
      seg.p  = 4'd0;
    end else begin
      seg.mm = {top[4:0], 1'b1};
      seg.p  = 4'(k - 5);
    end
    return seg;
  endfunction

  logic                 s0_valid, s0_exact;
  logic [15:0]          s0_a, s0_b;
  logic [IDW-1:0]       s0_id;
  logic                 s1_valid, s1_exact;
  logic [31:0]          s1_r;
  logic [IDW-1:0]       s1_id;
  logic [IDW-1:0]       last_grant;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_id;
  logic                 found;
  logic                 accept;
  logic                 s0_en, s1_en;
  logic [31:0]          prod;

  assign s1_en = !s1_valid || rsp_ready;
  assign s0_en = !s0_valid || s1_en;

  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant) + off) % NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
    if (!s0_en || rst) begin
      grant = '0;
      found = 1'b0;
    end
  end

  assign req_ready = grant;
  assign accept    = found;

  always_comb begin
    drum_seg_t   sa, sb;
    logic [11:0] mprod;
    logic [4:0]  shamt;
    sa    = drum_seg(s0_a);
    sb    = drum_seg(s0_b);
    mprod = 12'(sa.mm) * 12'(sb.mm);
    shamt = 5'(sa.p) + 5'(sb.p);
    if (s0_exact) prod = 32'(s0_a) * 32'(s0_b);
    else          prod = 32'(mprod) << shamt;
  end

  // NOTE: operand registers carry no reset; s0_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_a     <= req_a[int'(grant_id)*16 +: 16];
      s0_b     <= req_b[int'(grant_id)*16 +: 16];
      s0_id    <= grant_id;
      s0_exact <= exact_mask[grant_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid   <= 1'b0;
      s1_valid   <= 1'b0;
      s1_r       <= '0;
      s1_id      <= '0;
      s1_exact   <= 1'b0;
      last_grant <= IDW'(NREQ - 1);
      ops_done   <= '0;
    end else begin
      if (s1_en) s1_valid <= s0_valid;
      if (s1_en && s0_valid) begin
        s1_r     <= prod;
        s1_id    <= s0_id;
        s1_exact <= s0_exact;
      end
      if (accept) begin
        s0_valid   <= 1'b1;
        last_grant <= grant_id;
      end else if (s1_en) begin
        s0_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready && ops_done != 16'hFFFF) ops_done <= ops_done + 16'd1;
    end
  end

  assign rsp_valid = s1_valid;
  assign rsp_r     = s1_r;
  assign rsp_id    = s1_id;
  assign rsp_exact = s1_exact;
  assign busy      = s0_valid || s1_valid;

endmodule
